// File: rtl/wb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_sdram_port_arbiter
//
// Two-master Wishbone B3 arbiter. The CPU instruction bus (m0) and data bus (m1)
// share the single SDRAM controller slave port. All logic runs in the wb_clk
// domain.
//
// Arbitration is round-robin. A master holds its grant for the whole wb cycle
// (for as long as its cyc stays high), so incrementing bursts are never split.
// Slave-side outputs are combinational muxes driven by the registered grant.
// Once a master is granted, ack and err reach it with zero added latency.
//
// Optional feature (compile-time macro WB_ARB_TIMEOUT_EN):
//   Adds a watchdog. If a granted strobe gets no ack or err for TIMEOUT_CYCLES
//   cycles, the arbiter
//     - pulses err to the granted master for one cycle, and
//     - forces s_cyc_o/s_stb_o low for that cycle and the one after it.
//   When the macro is undefined there is no counter, and err is a plain
//   passthrough of s_err_i.
//
// Ports
//   wb_clk_i, wb_rst_i     clock; synchronous active-high reset
//   mN_adr_i ... mN_bte_i  Wishbone master request signals (N = 0, 1)
//   mN_dat_o               slave read data, broadcast to both masters
//   mN_ack_o, mN_err_o     response; only the granted master sees it
//   s_*_o                  request muxed from the granted master (0 when idle)
//   s_dat_i, s_ack_i,
//   s_err_i                SDRAM controller response
//   grant_o                one-hot grant {m1, m0}; 00 = idle
// -----------------------------------------------------------------------------
module wb_sdram_port_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   // master 0 (instruction bus)
   input  logic [AW-1:0]     m0_adr_i,
   input  logic [DW-1:0]     m0_dat_i,
   input  logic [DW/8-1:0]   m0_sel_i,
   input  logic              m0_we_i,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic [2:0]        m0_cti_i,
   input  logic [1:0]        m0_bte_i,
   output logic [DW-1:0]     m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   // master 1 (data bus)
   input  logic [AW-1:0]     m1_adr_i,
   input  logic [DW-1:0]     m1_dat_i,
   input  logic [DW/8-1:0]   m1_sel_i,
   input  logic              m1_we_i,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic [2:0]        m1_cti_i,
   input  logic [1:0]        m1_bte_i,
   output logic [DW-1:0]     m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   // slave (SDRAM controller)
   output logic [AW-1:0]     s_adr_o,
   output logic [DW-1:0]     s_dat_o,
   output logic [DW/8-1:0]   s_sel_o,
   output logic              s_we_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic [2:0]        s_cti_o,
   output logic [1:0]        s_bte_o,
   input  logic [DW-1:0]     s_dat_i,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   // debug
   output logic [1:0]        grant_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   last, last_nxt;   // master that was served most recently
   logic   gcyc, gstb;       // cyc/stb of the granted master
   logic   kill;             // watchdog forcing the slave cycle off
   logic   timeout;          // watchdog expiry pulse

   // ---------------------------------------------------------------------------
   // Grant state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         last  <= 1'b1;      // m0 wins the first contention
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_nxt = GNT0;
            else if (m1_cyc_i)        state_nxt = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               last_nxt  = 1'b0;
               // hand straight over when the other master is waiting
               state_nxt = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               last_nxt  = 1'b1;
               state_nxt = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Slave-side mux on the registered grant; everything is zero when idle
   // ---------------------------------------------------------------------------
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cti_o = '0;
      s_bte_o = '0;
      gcyc    = 1'b0;
      gstb    = 1'b0;
      case (state)
         GNT0: begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
            gcyc    = m0_cyc_i;
            gstb    = m0_stb_i;
         end
         GNT1: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
            gcyc    = m1_cyc_i;
            gstb    = m1_stb_i;
         end
         default: ;
      endcase
   end

   // A reset asserted mid-transfer drops the slave cycle immediately.
   // The controller shares this reset and aborts in the same cycle.
   assign s_cyc_o = gcyc & ~kill & ~wb_rst_i;
   assign s_stb_o = gstb & ~kill & ~wb_rst_i;

`ifdef WB_ARB_TIMEOUT_EN
   // ---------------------------------------------------------------------------
   // Watchdog: counts strobe cycles that have not yet received a response
   // ---------------------------------------------------------------------------
   localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wd_cnt;
   logic          wd_hold;   // keeps the slave cycle off one more cycle

   // Fires on the TIMEOUT_CYCLES-th consecutive unanswered strobe cycle.
   assign timeout = gstb & ~s_ack_i & ~s_err_i & ~wb_rst_i & (wd_cnt == CNT_LAST);
   assign kill    = timeout | wd_hold;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wd_cnt  <= '0;
         wd_hold <= 1'b0;
      end else begin
         wd_hold <= timeout;
         if (!s_stb_o || s_ack_i || s_err_i) wd_cnt <= '0;
         else                                wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout = 1'b0;
   assign kill    = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Response routing: only the granted master sees ack/err
   // ---------------------------------------------------------------------------
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = (state == GNT0) & s_ack_i & ~wb_rst_i;
   assign m1_ack_o = (state == GNT1) & s_ack_i & ~wb_rst_i;
   assign m0_err_o = (state == GNT0) & (s_err_i | timeout) & ~wb_rst_i;
   assign m1_err_o = (state == GNT1) & (s_err_i | timeout) & ~wb_rst_i;

   assign grant_o  = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_sdram_port_arbiter
//
// Directed testbench for wb_sdram_port_arbiter, covering:
//   - reset behaviour
//   - a single read
//   - round-robin contention
//   - an 8-beat burst that must not be split
//   - request withdrawal
//   - reset asserted mid-transfer
//   - a hung slave (watchdog behaviour depends on WB_ARB_TIMEOUT_EN)
//
// Timing: inputs are driven 1 time unit after a rising edge, and outputs are
// sampled 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_wb_sdram_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] m0_adr, m1_adr, s_adr;
   logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
   logic [3:0]    m0_sel, m1_sel, s_sel;
   logic          m0_we, m1_we, s_we;
   logic          m0_cyc, m1_cyc, m0_stb, m1_stb, s_cyc, s_stb;
   logic [2:0]    m0_cti, m1_cti, s_cti;
   logic [1:0]    m0_bte, m1_bte, s_bte;
   logic          m0_ack, m1_ack, m0_err, m1_err, s_ack, s_err;
   logic [1:0]    grant;

   int n_chk  = 0;
   int n_pass = 0;
   int acks;

   always #5 clk = ~clk;

   wb_sdram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i(clk),    .wb_rst_i(rst),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),  .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
      .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),  .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
      .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb),  .s_cti_o(s_cti), .s_bte_o(s_bte),
      .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
      .grant_o(grant)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      m0_adr = 32'h0;  m0_wdat = 32'h1111_0000; m0_sel = 4'hF; m0_we = 1'b0;
      m1_adr = 32'h0;  m1_wdat = 32'h2222_0000; m1_sel = 4'h3; m1_we = 1'b1;
      m0_cti = 3'b000; m0_bte = 2'b00; m1_cti = 3'b000; m1_bte = 2'b00;
      m0_cyc = 1'b1;   m0_stb = 1'b1;  m1_cyc = 1'b1;   m1_stb = 1'b1;
      s_rdat = 32'h0;  s_ack  = 1'b1;  s_err  = 1'b1;

      // ---- reset held 3 cycles with both masters requesting ----
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_grant", grant, 2'b00);
         check("rst_scyc",  s_cyc, 1'b0);
         check("rst_ack0",  m0_ack, 1'b0);
         check("rst_err1",  m1_err, 1'b0);
      end
      rst = 1'b0; s_ack = 1'b0; s_err = 1'b0;
      #1 check("rel_idle", grant, 2'b00);
      step();
      check("rel_grant_m0", grant, 2'b01);
      check("rel_scyc",     s_cyc, 1'b1);
      m0_cyc = 1'b0; m0_stb = 1'b0;
      step();
      check("rel_grant_m1", grant, 2'b10);
      m1_cyc = 1'b0; m1_stb = 1'b0;
      step();
      check("rel_back_idle", grant, 2'b00);

      // ---- single m1 read at 0x40 ----
      m1_adr = 32'h0000_0040; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
      #1 check("rd_idle_adr", s_adr, 32'h0);
      step();
      check("rd_grant", grant, 2'b10);
      check("rd_sadr",  s_adr, 32'h0000_0040);
      check("rd_swe",   s_we,  1'b0);
      s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
      #1;
      check("rd_ack1", m1_ack,  1'b1);
      check("rd_dat1", m1_rdat, 32'hDEAD_BEEF);
      check("rd_ack0", m0_ack,  1'b0);
      step();
      s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      step();
      check("rd_idle", grant, 2'b00);

      // ---- contention: single-beat cycles alternate without an idle gap ----
      m0_adr = 32'h100; m1_adr = 32'h200; m1_we = 1'b1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      step();
      for (int k = 0; k < 4; k++) begin
         logic [1:0] g;
         g = (k % 2 == 0) ? 2'b01 : 2'b10;
         check("rr_grant", grant, g);
         check("rr_sadr",  s_adr, (k % 2 == 0) ? 32'h100 : 32'h200);
         check("rr_swe",   s_we,  (k % 2 == 0) ? 1'b0 : 1'b1);
         s_ack = 1'b1;
         #1;
         check("rr_ack0", m0_ack, g[0]);
         check("rr_ack1", m1_ack, g[1]);
         step();
         s_ack = 1'b0;
         if (g[0]) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
         else      begin m1_cyc = 1'b0; m1_stb = 1'b0; end
         #1 check("rr_hold", grant, g);
         step();
         m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      end
      check("rr_wrap", grant, 2'b01);
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      step();
      check("rr_idle", grant, 2'b00);

      // ---- 8-beat m0 burst; m1 requests at beat 2 and must wait ----
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_bte = 2'b00;
      step();
      acks = 0;
      for (int b = 0; b < 8; b++) begin
         m0_adr = 32'h1000 + 32'(4 * b);
         m0_cti = (b == 7) ? 3'b111 : 3'b010;
         if (b == 2) begin m1_cyc = 1'b1; m1_stb = 1'b1; end
         s_ack = 1'b1;
         #1;
         check("bu_grant", grant, 2'b01);
         check("bu_sadr",  s_adr, 32'h1000 + 32'(4 * b));
         check("bu_scti",  s_cti, (b == 7) ? 3'b111 : 3'b010);
         check("bu_ack1",  m1_ack, 1'b0);
         if (m0_ack) acks++;
         step();
      end
      check("bu_acks", acks, 8);
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      #1 check("bu_hold", grant, 2'b01);
      step();
      check("bu_switch", grant, 2'b10);
      check("bu_sadr1",  s_adr, 32'h200);
      m1_cyc = 1'b0; m1_stb = 1'b0;
      step();
      check("bu_idle", grant, 2'b00);

      // ---- withdrawal: m1 asks for 2 cycles while m0 is granted ----
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_cti = 3'b000;
      step();
      m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("wd_grant", grant, 2'b01);
         check("wd_ack1",  m1_ack, 1'b0);
         check("wd_ack0",  m0_ack, 1'b1);
         step();
      end
      m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
      step();
      m0_cyc = 1'b0; m0_stb = 1'b0;
      step();
      check("wd_idle", grant, 2'b00);

      // ---- reset asserted mid-transfer ----
      m0_cyc = 1'b1; m0_stb = 1'b1;
      step();
      check("mr_grant", grant, 2'b01);
      rst = 1'b1; s_ack = 1'b1; s_err = 1'b1;
      #1;
      check("mr_scyc", s_cyc,  1'b0);
      check("mr_ack0", m0_ack, 1'b0);
      check("mr_err0", m0_err, 1'b0);
      step();
      check("mr_idle", grant, 2'b00);
      rst = 1'b0; s_ack = 1'b0; s_err = 1'b0;
      step();
      check("mr_regrant", grant, 2'b01);
      m0_cyc = 1'b0; m0_stb = 1'b0;
      step();

      // ---- slave error passthrough to the granted master only ----
      m1_cyc = 1'b1; m1_stb = 1'b1;
      step();
      s_err = 1'b1;
      #1;
      check("er_err1", m1_err, 1'b1);
      check("er_err0", m0_err, 1'b0);
      step();
      s_err = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      step();

      // ---- hung slave: ack stuck low ----
      m0_cyc = 1'b1; m0_stb = 1'b1;
      step();
`ifdef WB_ARB_TIMEOUT_EN
      for (int c = 1; c <= 17; c++) begin
         check("to_err0", m0_err, (c == 16) ? 1'b1 : 1'b0);
         check("to_scyc", s_cyc,  (c == 16 || c == 17) ? 1'b0 : 1'b1);
         step();
      end
      m0_cyc = 1'b0; m0_stb = 1'b0;
      step();
      check("to_idle", grant, 2'b00);
`else
      for (int c = 1; c <= 40; c++) begin
         check("hang_err0", m0_err, 1'b0);
         check("hang_scyc", s_cyc,  1'b1);
         step();
      end
      m0_cyc = 1'b0; m0_stb = 1'b0;
      step();
      check("hang_idle", grant, 2'b00);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
